// File: rtl/dm_cache_pkg.sv
// Shared types and width helpers for the direct-mapped cache controller.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL_RESP, WR_MEM
  } state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Default geometry and the widths derived from it.
  localparam int ADDR_W_D = 15;
  localparam int WPL_D    = 4;
  localparam int LINES_D  = 1024;
  localparam int OFF_W_D  = clog2(WPL_D);
  localparam int IDX_W_D  = clog2(LINES_D);
  localparam int TAG_W_D  = ADDR_W_D - IDX_W_D - OFF_W_D;

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side and memory-side handshake bundle of the cache controller.
interface dm_cache_if #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32,
  parameter int WPL    = 4
);
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_we;
  logic [ADDR_W-1:0]       cpu_req_addr;
  logic [WORD_W-1:0]       cpu_req_wdata;
  logic                    cpu_resp_valid;
  logic [WORD_W-1:0]       cpu_resp_data;
  logic                    cpu_resp_hit;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [WORD_W-1:0]       mem_req_wdata;
  logic                    mem_rd_valid;
  logic [WORD_W*WPL-1:0]   mem_rd_data;

  // Cache side.
  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
           mem_req_ready, mem_rd_valid, mem_rd_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  // CPU plus backing memory side.
  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
           mem_req_ready, mem_rd_valid, mem_rd_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/dm_cache_ctrl_ram.sv
// Tag + line storage: synchronous read, one write port, per-word write enable.
module cache_line_ram #(
  parameter int IDX_W  = 10,
  parameter int TAG_W  = 3,
  parameter int WORD_W = 32,
  parameter int WPL    = 4
) (
  input  logic                         clk,
  input  logic                         rd_en,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [WPL-1:0][WORD_W-1:0]   rd_line,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic                         wr_tag_en,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [WPL-1:0]               wr_word_en,
  input  logic [WPL-1:0][WORD_W-1:0]   wr_line
);
  localparam int DEPTH = 1 << IDX_W;

  logic [TAG_W-1:0] tag_mem [DEPTH];

  // Tag array: written only on refill, read on request accept.
  always_ff @(posedge clk) begin
    if (wr_tag_en) tag_mem[wr_idx] <= wr_tag;
    if (rd_en)     rd_tag <= tag_mem[rd_idx];
  end

  for (genvar w = 0; w < WPL; w++) begin : g_word
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word;

    // One bank per word so a write hit touches only its own word.
    always_ff @(posedge clk) begin
      if (wr_word_en[w]) mem[wr_idx] <= wr_line[w];
      if (rd_en)         rd_word <= mem[rd_idx];
    end

    assign rd_line[w] = rd_word;
  end
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through/no-allocate cache with blocking miss handling.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32,
  parameter int WPL    = 4,
  parameter int LINES  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  dm_cache_if.slave        bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int OFF_W = clog2(WPL);
  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t                     state, state_nxt;
  logic [LINES-1:0]           valid;
  logic [ADDR_W-1:0]          req_addr;
  logic                       req_we, hit_q;
  logic [WORD_W-1:0]          req_wdata, refill_word;
  logic [TAG_W-1:0]           req_tag, rd_tag;
  logic [IDX_W-1:0]           req_idx;
  logic [OFF_W-1:0]           req_off;
  logic [WPL-1:0][WORD_W-1:0] rd_line, mem_line, wr_line;
  logic [WPL-1:0]             wr_word_en;
  logic                       wr_tag_en, accept, lookup_hit, refill;

  assign {req_tag, req_idx, req_off} = req_addr;
  assign mem_line   = bus.mem_rd_data;
  assign accept     = (state == IDLE) && !flush && bus.cpu_req_valid;
  assign lookup_hit = valid[req_idx] && (rd_tag == req_tag);
  assign refill     = (state == MISS_WAIT) && bus.mem_rd_valid;

  cache_line_ram #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WORD_W(WORD_W), .WPL(WPL)) u_ram (
    .clk(clk), .rd_en(accept), .rd_idx(bus.cpu_req_addr[OFF_W +: IDX_W]),
    .rd_tag(rd_tag), .rd_line(rd_line), .wr_idx(req_idx), .wr_tag_en(wr_tag_en),
    .wr_tag(req_tag), .wr_word_en(wr_word_en), .wr_line(wr_line)
  );

  // Array write select: full line + tag on refill, single word on write hit.
  always_comb begin
    wr_tag_en  = 1'b0;
    wr_word_en = '0;
    wr_line    = mem_line;
    if (refill) begin
      wr_tag_en  = 1'b1;
      wr_word_en = '1;
    end else if (state == LOOKUP && req_we && lookup_hit) begin
      wr_word_en[req_off] = 1'b1;
      wr_line             = {WPL{req_wdata}};
    end
  end

  // State register; reset abandons any in-flight miss or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and all bus outputs; outputs idle at zero outside their states.
  always_comb begin
    state_nxt          = state;
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_data  = '0;
    bus.cpu_resp_hit   = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_wdata  = '0;
    unique case (state)
      IDLE: begin
        bus.cpu_req_ready = !flush;
        if (accept) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (req_we) state_nxt = WR_MEM;
        else if (lookup_hit) begin
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_data  = rd_line[req_off];
          bus.cpu_resp_hit   = 1'b1;
          state_nxt          = IDLE;
        end else state_nxt = MISS_REQ;
      end
      MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (bus.mem_req_ready) state_nxt = MISS_WAIT;
      end
      MISS_WAIT: if (bus.mem_rd_valid) state_nxt = REFILL_RESP;
      REFILL_RESP: begin
        bus.cpu_resp_valid = 1'b1;
        bus.cpu_resp_data  = refill_word;
        state_nxt          = IDLE;
      end
      WR_MEM: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = req_addr;
        bus.mem_req_wdata = req_wdata;
        if (bus.mem_req_ready) begin
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_hit   = hit_q;
          state_nxt          = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, write-hit flag for WR_MEM, and the word returned after refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr    <= '0;
      req_we      <= 1'b0;
      req_wdata   <= '0;
      hit_q       <= 1'b0;
      refill_word <= '0;
    end else begin
      if (accept) begin
        req_addr  <= bus.cpu_req_addr;
        req_we    <= bus.cpu_req_we;
        req_wdata <= bus.cpu_req_wdata;
      end
      if (state == LOOKUP) hit_q <= lookup_hit;
      if (refill) refill_word <= mem_line[req_off];
    end
  end

  // Valid bits live in flops so flush clears all lines in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      valid <= '0;
    else if (state == IDLE && flush) valid <= '0;
    else if (refill)                 valid[req_idx] <= 1'b1;
  end

  // Saturating hit/miss statistics, counted once per lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + CNT_W'(1);
      else if (!lookup_hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomized bench for dm_cache_ctrl: behavioural cache/memory model plus directed pins.
module tb_dm_cache_ctrl;
  localparam int AW = 15, WW = 32, WPL = 4, LINES = 1024, CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dm_cache_if #(.ADDR_W(AW), .WORD_W(WW), .WPL(WPL)) bus();

  dm_cache_ctrl #(.ADDR_W(AW), .WORD_W(WW), .WPL(WPL), .LINES(LINES), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // Backing memory: untouched words read as 0xD000_0000 | address.
  logic [WW-1:0] mem [int];
  function automatic logic [WW-1:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : (32'hD000_0000 | 32'(a));
  endfunction

  // Cache model: which tag each line holds; data always equals memory (write-through).
  bit mv [LINES];
  int mt [LINES];
  int m_hit, m_miss;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Outstanding-transaction tracking.
  bit busy = 0, t_we, t_hit, mem_done, rd_seen;
  int age, t_addr;
  logic [WW-1:0] t_wdata, t_data;
  logic [WW-1:0] last_data;
  bit last_hit;
  int last_age;

  // Memory responder knobs.
  int rdy_mode = 0;  // 0 random, 1 forced low
  bit hold_rd = 0, spur_en = 0;

  // Compare process: expected outputs every cycle from the transaction model.
  bit e_ready, e_rv, e_hit, e_mv, e_we;
  int e_addr;
  logic [WW-1:0] e_data, e_wd;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        for (int i = 0; i < LINES; i++) mv[i] = 0;
        m_hit = 0;
        m_miss = 0;
      end else begin
        e_ready = !busy && !flush;
        e_rv = 0; e_hit = 0; e_data = '0; e_mv = 0; e_we = 0; e_addr = 0; e_wd = '0;
        if (busy) begin
          if (age == 1) begin
            if (!t_we && t_hit) begin e_rv = 1; e_hit = 1; e_data = t_data; end
          end else if (!mem_done) begin
            e_mv = 1; e_we = t_we; e_wd = t_wdata;
            e_addr = t_we ? t_addr : (t_addr & ~(WPL - 1));
            if (t_we && bus.mem_req_ready) begin e_rv = 1; e_hit = t_hit; end
          end else if (rd_seen) begin
            e_rv = 1; e_data = t_data;
          end
        end
        chk("cpu_req_ready", bus.cpu_req_ready, e_ready);
        chk("cpu_resp_valid", bus.cpu_resp_valid, e_rv);
        chk("mem_req_valid", bus.mem_req_valid, e_mv);
        if (e_rv) begin
          chk("cpu_resp_data", bus.cpu_resp_data, e_data);
          chk("cpu_resp_hit", bus.cpu_resp_hit, e_hit);
          last_data = bus.cpu_resp_data;
          last_hit = bus.cpu_resp_hit;
          last_age = age;
        end
        if (e_mv) begin
          chk("mem_req_we", bus.mem_req_we, e_we);
          chk("mem_req_addr", bus.mem_req_addr, e_addr);
          if (e_we) chk("mem_req_wdata", bus.mem_req_wdata, e_wd);
        end
        if (!busy) begin
          chk("hit_cnt", hit_cnt, sat(m_hit));
          chk("miss_cnt", miss_cnt, sat(m_miss));
        end
        // advance the model by one cycle
        if (busy) begin
          if (e_rv) busy = 0;
          else begin
            if (age >= 2 && !mem_done && bus.mem_req_ready) mem_done = 1;
            else if (mem_done && bus.mem_rd_valid) rd_seen = 1;
            age++;
          end
        end else if (flush) begin
          for (int i = 0; i < LINES; i++) mv[i] = 0;
        end else if (bus.cpu_req_valid) begin
          int idx, tag;
          t_addr = int'(bus.cpu_req_addr);
          t_we = bus.cpu_req_we;
          t_wdata = bus.cpu_req_wdata;
          idx = (t_addr / WPL) % LINES;
          tag = t_addr / (WPL * LINES);
          t_hit = mv[idx] && mt[idx] == tag;
          if (t_hit) m_hit++; else m_miss++;
          if (t_we) begin
            t_data = '0;
            mem[t_addr] = t_wdata;
          end else begin
            t_data = mem_rd(t_addr);
            if (!t_hit) begin mv[idx] = 1; mt[idx] = tag; end
          end
          busy = 1; age = 1; mem_done = 0; rd_seen = 0;
        end
      end
    end
  end

  // Memory responder: random ready, random refill latency, stray rd_valid when idle.
  bit pend = 0;
  int paddr, dly;
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      else if (bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we && !pend) begin
        pend = 1;
        paddr = int'(bus.mem_req_addr);
        dly = $urandom_range(0, 3);
      end
      @(posedge clk);
      #1;
      bus.mem_req_ready = (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      bus.mem_rd_valid = 1'b0;
      for (int k = 0; k < WPL; k++) bus.mem_rd_data[k*WW +: WW] = $urandom;
      if (pend) begin
        if (!hold_rd) begin
          if (dly == 0) begin
            bus.mem_rd_valid = 1'b1;
            for (int k = 0; k < WPL; k++) bus.mem_rd_data[k*WW +: WW] = mem_rd(paddr + k);
            pend = 0;
          end else dly--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) bus.mem_rd_valid = 1'b1;
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.cpu_req_ready) ok = 1;
    end
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = '0;
    bus.cpu_req_wdata = '0;
    if (!ok) tmo("accept");
  endtask

  task automatic issue(input bit we, input int a, input logic [WW-1:0] d);
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we = we;
    bus.cpu_req_addr = AW'(a);
    bus.cpu_req_wdata = d;
    wait_accept();
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) tmo("response");
    @(negedge clk);
  endtask

  task automatic rd(input int a);
    issue(0, a, '0);
    wait_idle();
  endtask

  task automatic wr(input int a, input logic [WW-1:0] d);
    issue(1, a, d);
    wait_idle();
  endtask

  task automatic check_reset(input string nm);
    @(negedge clk);
    chk({nm, ".ready"}, bus.cpu_req_ready, 1);
    chk({nm, ".resp_valid"}, bus.cpu_resp_valid, 0);
    chk({nm, ".resp_data"}, bus.cpu_resp_data, 0);
    chk({nm, ".resp_hit"}, bus.cpu_resp_hit, 0);
    chk({nm, ".mem_valid"}, bus.mem_req_valid, 0);
    chk({nm, ".mem_we"}, bus.mem_req_we, 0);
    chk({nm, ".mem_addr"}, bus.mem_req_addr, 0);
    chk({nm, ".mem_wdata"}, bus.mem_req_wdata, 0);
    chk({nm, ".hit_cnt"}, hit_cnt, 0);
    chk({nm, ".miss_cnt"}, miss_cnt, 0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1 rst_n = 1'b0;
    check_reset(nm);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = '0;
    bus.cpu_req_wdata = '0;
    check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // cold miss then hit on 0x0005
    rd(32'h0005);
    chk("cold.hit", last_hit, 0);
    chk("cold.data", last_data, 32'hD000_0005);
    chk("cold.miss_cnt", miss_cnt, 1);
    rd(32'h0005);
    chk("reread.hit", last_hit, 1);
    chk("reread.data", last_data, 32'hD000_0005);
    chk("reread.latency", last_age, 1);

    // write-through hit, then uncached write (no allocate)
    wr(32'h0006, 32'hDEAD_BEEF);
    chk("wr_hit.hit", last_hit, 1);
    rd(32'h0006);
    chk("rd_after_wr.hit", last_hit, 1);
    chk("rd_after_wr.data", last_data, 32'hDEAD_BEEF);
    wr(32'h0300, 32'h1234_5678);
    chk("wr_miss.hit", last_hit, 0);
    rd(32'h0300);
    chk("no_alloc.hit", last_hit, 0);
    chk("no_alloc.data", last_data, 32'h1234_5678);

    // conflict on index 1
    rd(32'h1004); chk("conf1.hit", last_hit, 0);
    rd(32'h2004); chk("conf2.hit", last_hit, 0);
    rd(32'h1004); chk("conf3.hit", last_hit, 0);
    chk("conf3.data", last_data, 32'hD000_1004);

    // memory not ready for several cycles; flush while busy is ignored
    rdy_mode = 1;
    issue(0, 32'h0123, '0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall.mem_valid", bus.mem_req_valid, 1);
    chk("stall.mem_addr", bus.mem_req_addr, 15'h0120);
    rdy_mode = 0;
    wait_idle();
    chk("stall.data", last_data, 32'hD000_0123);
    rd(32'h0123);
    chk("busy_flush_ignored.hit", last_hit, 1);

    // flush in idle, and flush colliding with a request
    rd(32'h0040);
    rd(32'h0040); chk("pre_flush.hit", last_hit, 1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    rd(32'h0040); chk("post_flush.hit", last_hit, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr = 15'h0040;
    @(negedge clk);
    chk("flush_blocks.ready", bus.cpu_req_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    wait_accept();
    wait_idle();
    chk("flush_collide.hit", last_hit, 0);

    // reset while waiting on refill data
    hold_rd = 1;
    issue(0, 32'h0200, '0);
    for (int i = 0; i < 100 && !mem_done; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    check_reset("mid_refill");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_rd = 0;
    rd(32'h0200);
    chk("after_reset.hit", last_hit, 0);

    // counter saturation
    do_reset("pre_sat");
    rd(32'h0400);
    for (int i = 0; i < 5; i++) rd(32'h0400);
    chk("sat.hit_cnt", hit_cnt, 3);
    chk("sat.miss_cnt", miss_cnt, 1);

    // randomized traffic with stray refill beats and idle flushes
    spur_en = 1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end else begin
        int a;
        a = (($urandom_range(0, 3) * LINES) + $urandom_range(0, 3)) * WPL + $urandom_range(0, 3);
        if ($urandom_range(0, 2) == 0) wr(a, $urandom);
        else rd(a);
      end
      if (n % 60 == 59) do_reset("rand_reset");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    spur_en = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised direct-mapped data cache with a blocking miss-handling controller. It sits between the CPU load/store port and the backing data memory. Read misses refill a whole line from memory over a valid/ready request and valid-only return channel. Writes are write-through, no-allocate. The block also provides single-cycle flush and saturating hit/miss counters.

## Interface
Parameters:
- `ADDR_W`, 15: word address width.
- `WORD_W`, 32: data word width.
- `WPL`, 4: words per line; power of two, ≥2.
- `LINES`, 1024: number of lines; power of two.
- `CNT_W`, 16: statistics counter width.
- Derived: `OFF_W=log2(WPL)`, `IDX_W=log2(LINES)`, `TAG_W=ADDR_W-IDX_W-OFF_W` (defaults 2/10/3).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `flush` in 1: invalidate all lines.
- `cpu_req_valid` in 1, `cpu_req_ready` out 1: request handshake.
- `cpu_req_we` in 1: 1 = write.
- `cpu_req_addr` in ADDR_W: word address {tag, index, offset}.
- `cpu_req_wdata` in WORD_W: write data.
- `cpu_resp_valid` out 1: one-cycle response pulse.
- `cpu_resp_data` out WORD_W: read data; 0 for writes.
- `cpu_resp_hit` out 1: request hit, qualified by `cpu_resp_valid`.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_req_we` out 1: 1 = word write, 0 = line read.
- `mem_req_addr` out ADDR_W: line read uses offset bits = 0; write uses the full word address.
- `mem_req_wdata` out WORD_W: write data.
- `mem_rd_valid` in 1: refill data valid.
- `mem_rd_data` in WORD_W*WPL: refill line; word k at bits [k*WORD_W +: WORD_W].
- `hit_cnt`, `miss_cnt` out CNT_W: saturating counters.

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL_RESP, WR_MEM.
- IDLE:
  - `cpu_req_ready=1` unless `flush`=1.
  - `flush` has priority: clears every valid bit on that edge, with `cpu_req_ready=0` that cycle.
  - On accept: register the request, read the tag/data arrays synchronously, go to LOOKUP.
- LOOKUP: hit = valid[idx] & (tag[idx]==req tag).
  - Read hit: `cpu_resp_valid=1`, data = word[offset], `hit=1`; `hit_cnt`+1; go to IDLE.
  - Read miss: `miss_cnt`+1; go to MISS_REQ.
  - Write: hit updates the cached word on this edge (tag/valid unchanged); miss leaves the array untouched. Count hit or miss; go to WR_MEM.
- MISS_REQ: `mem_req_valid=1`, `we=0`, line address. Hold stable until `mem_req_ready`, then go to MISS_WAIT.
- MISS_WAIT: on `mem_rd_valid`, write the line, tag, and valid=1; go to REFILL_RESP.
- REFILL_RESP: `cpu_resp_valid=1`, data = requested word from the new line, `hit=0`; go to IDLE.
- WR_MEM: `mem_req_valid=1`, `we=1`, word address and wdata. On `mem_req_ready`: `cpu_resp_valid=1`, `hit`=the LOOKUP result, go to IDLE.
- Counters saturate at all-ones and never wrap.
- `mem_rd_valid` outside MISS_WAIT is ignored.
- `flush` outside IDLE is ignored; it is not latched.

## Timing
- Reset values: state IDLE; all valid bits 0; `cpu_req_ready=1`; `cpu_resp_valid=0`; `cpu_resp_data=0`; `cpu_resp_hit=0`; `mem_req_valid=0`; `mem_req_we=0`; `mem_req_addr=0`; `mem_req_wdata=0`; counters 0. Data and tag arrays are not reset.
- Read hit: accept at edge N, response during cycle N+1, ready again at N+2. Throughput is one request per 2 cycles.
- Read miss: response is 1 cycle after the `mem_rd_valid` edge.
- Write: response occurs in the same cycle as the memory handshake.
- Blocking: `cpu_req_ready=0` in every state except IDLE.
- Reset mid-refill or mid-write: return to IDLE immediately, drop `mem_req_valid`, write nothing into the arrays, emit no response.

## Structure
- Package `dm_cache_pkg`: state enum, a `clog2` helper, and the derived-width localparams.
- Sub-module `cache_line_ram`: a LINES-deep, synchronous-read, single-write-port array of {tag, line} with a per-word write enable. Valid bits stay in the controller as flops so reset and flush act on them directly.

## Test plan
- Cold read 0x0005: miss; memory line {D3,D2,D1,D0} → resp data D1, `hit=0`, `miss_cnt=1`. Re-read 0x0005 → D1, `hit=1`, response at accept+1.
- Conflict: read 0x1004, then 0x2004 (same index, different tag) → both miss. Re-read 0x1004 → miss again.
- Write 0x0006=0xDEADBEEF after line fill → `mem_req` we=1 addr 0x0006. Read 0x0006 → hit, 0xDEADBEEF. Write to an uncached address → no allocate; the following read misses.
- `mem_req_ready` held low 5 cycles in MISS_REQ → addr, valid, and we stable throughout. Spurious `mem_rd_valid` in IDLE → no state change.
- `flush` pulse in IDLE after hits → next read of the same address misses. `flush` coincident with `cpu_req_valid` → request not accepted that cycle.
- `rst_n` low during MISS_WAIT → outputs return to reset values. Subsequent read of the same address misses. Saturation check with `CNT_W=2`: 5 hits → `hit_cnt=3`.
